// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-coded copy of its value and a
// one-cycle roll-over pulse. Every output comes straight from a flop.
module gray_code_counter #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_nextBin;
  logic             w_nextWrap;

  function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The extra top bit of each sum is the carry/borrow; it only feeds wrap.
  always_comb begin
    w_inc      = {1'b0, r_bin} + ONE;
    w_dec      = {1'b0, r_bin} - ONE;
    w_nextBin  = r_bin;
    w_nextWrap = 1'b0;
    if (load) begin
      w_nextBin = load_val;
    end else if (en) begin
      if (up_dn) begin
        w_nextBin  = w_inc[WIDTH-1:0];
        w_nextWrap = w_inc[WIDTH];
      end else begin
        w_nextBin  = w_dec[WIDTH-1:0];
        w_nextWrap = w_dec[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= RST_VAL;
      r_gray <= toGray(RST_VAL);
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_nextBin;
      r_gray <= toGray(w_nextBin);
      r_wrap <= w_nextWrap;
    end
  end

  assign bin_o  = r_bin;
  assign gray_o = r_gray;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed-vector bench for gray_code_counter (WIDTH=3, RST_VAL=0): stimulus
// queues hand-computed responses, a monitor compares them one edge later.
module tb_gray_code_counter;

  localparam int WIDTH = 3;

  typedef struct packed {
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic [7:0]       tag;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic             wrap;

  expect_t expQ[$];
  int      vectorCount = 0;
  int      missCount   = 0;

  gray_code_counter #(.WIDTH(WIDTH), .RST_VAL(3'b000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bin_o    (bin_o),
    .gray_o   (gray_o),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the matching response is due after the next rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] eb,
                               input logic [WIDTH-1:0] eg, input logic ew, input logic [7:0] tag);
    expect_t x;
    @(negedge clk);
    rst_n    = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = lv;
    x.bin  = eb;
    x.gray = eg;
    x.wrap = ew;
    x.tag  = tag;
    expQ.push_back(x);
  endtask

  task automatic checkOutput(input expect_t x);
    vectorCount++;
    if (bin_o !== x.bin || gray_o !== x.gray || wrap !== x.wrap) begin
      missCount++;
      $display("[TB] FAIL vec%0d: got bin=%b gray=%b wrap=%b, expected bin=%b gray=%b wrap=%b",
               x.tag, bin_o, gray_o, wrap, x.bin, x.gray, x.wrap);
    end
  endtask

  initial begin
    expect_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin
    int waitCycles;
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 3'b101;

    // Reset overrides load and en
    applyStimulus(0, 1, 1, 1, 3'b101, 3'b000, 3'b000, 0, 0);
    applyStimulus(0, 1, 1, 1, 3'b101, 3'b000, 3'b000, 0, 1);

    // Full up cycle, wrap only on 111->000
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b001, 3'b001, 0, 2);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b010, 3'b011, 0, 3);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b011, 3'b010, 0, 4);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b100, 3'b110, 0, 5);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b101, 3'b111, 0, 6);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b110, 3'b101, 0, 7);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b111, 3'b100, 0, 8);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b000, 3'b000, 1, 9);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b001, 3'b001, 0, 10);

    // Load 000 then count down through the borrow
    applyStimulus(1, 0, 1, 1, 3'b000, 3'b000, 3'b000, 0, 11);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b111, 3'b100, 1, 12);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b110, 3'b101, 0, 13);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b101, 3'b111, 0, 14);

    // Load wins over en; loading 111 never pulses wrap
    applyStimulus(1, 1, 1, 1, 3'b101, 3'b101, 3'b111, 0, 15);
    applyStimulus(1, 1, 1, 1, 3'b111, 3'b111, 3'b100, 0, 16);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b000, 3'b000, 1, 17);
    applyStimulus(1, 1, 0, 1, 3'b000, 3'b000, 3'b000, 0, 18);

    // Hold for three cycles, up_dn wiggling has no effect
    applyStimulus(1, 0, 1, 0, 3'b011, 3'b000, 3'b000, 0, 19);
    applyStimulus(1, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 20);
    applyStimulus(1, 0, 1, 0, 3'b011, 3'b000, 3'b000, 0, 21);

    // Up to 010, then reverse
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b001, 3'b001, 0, 22);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b010, 3'b011, 0, 23);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b001, 3'b001, 0, 24);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b010, 3'b011, 0, 25);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b001, 3'b001, 0, 26);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b000, 3'b000, 0, 27);
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b111, 3'b100, 1, 28);

    // Reset mid-count discards the step, then counting resumes from zero
    applyStimulus(1, 1, 0, 0, 3'b000, 3'b110, 3'b101, 0, 29);
    applyStimulus(0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 0, 30);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b001, 3'b001, 0, 31);
    applyStimulus(1, 1, 1, 1, 3'b110, 3'b110, 3'b101, 0, 32);
    applyStimulus(1, 1, 1, 0, 3'b000, 3'b111, 3'b100, 0, 33);
    applyStimulus(1, 0, 1, 0, 3'b000, 3'b111, 3'b100, 0, 34);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
